// File: rtl/instr_encode_stream.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encode_stream
//  Purpose  : Streaming RV32I instruction encoder. Packs decoded instruction
//             fields into a 32-bit word, tags it with a sequential byte
//             address and buffers it in a 2-entry FIFO towards a consumer.
//  Ports    : clk, rst_n (async, active-low)
//             load_base/base_addr   - reload the address counter
//             in_valid/in_ready     - field-set handshake
//             in_opcode..in_imm     - decoded instruction fields
//             out_valid/out_ready   - encoded-word handshake
//             out_instr/out_addr    - encoded word and its byte address
//             out_err               - encoding error for the head word
//             word_count            - words popped since reset (wraps)
//  Options  : ENC_RANGE_CHECK_EN - flag immediates that do not fit their
//             instruction format (word still built from truncated bits).
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encode_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_base,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_func3,
    input  logic [6:0]  in_func7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] word_count
);

    localparam logic [6:0]  C_OP_R     = 7'b0110011;
    localparam logic [6:0]  C_OP_IMM   = 7'b0010011;
    localparam logic [6:0]  C_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  C_OP_JALR  = 7'b1100111;
    localparam logic [6:0]  C_OP_STORE = 7'b0100011;
    localparam logic [6:0]  C_OP_BR    = 7'b1100011;
    localparam logic [6:0]  C_OP_JAL   = 7'b1101111;
    localparam logic [6:0]  C_OP_LUI   = 7'b0110111;
    localparam logic [6:0]  C_OP_AUIPC = 7'b0010111;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] w_word;
    logic        w_unknown;
    logic        w_err;
    logic        w_is_shift;

    assign w_is_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);

    always_comb begin
        w_word    = C_NOP;
        w_unknown = 1'b0;
        case (in_opcode)
            C_OP_R:
                w_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
            C_OP_IMM: begin
                // Shift-immediates carry the funct7 qualifier in the top bits
                if (w_is_shift)
                    w_word = {in_func7, in_imm[4:0], in_rs1, in_func3, in_rd, in_opcode};
                else
                    w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
            end
            C_OP_LOAD, C_OP_JALR:
                w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
            C_OP_STORE:
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
            C_OP_BR:
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                          in_imm[4:1], in_imm[11], in_opcode};
            C_OP_JAL:
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
            C_OP_LUI, C_OP_AUIPC:
                w_word = {in_imm[31:12], in_rd, in_opcode};
            default:
                w_unknown = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // An immediate fits an N-bit signed field when all bits from N-1 upward
    // are identical.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;
    logic w_range_bad;

    assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_range_bad = 1'b0;
        case (in_opcode)
            C_OP_IMM:              w_range_bad = w_is_shift ? (|in_imm[31:5]) : ~w_fit12;
            C_OP_LOAD, C_OP_JALR,
            C_OP_STORE:            w_range_bad = ~w_fit12;
            C_OP_BR:               w_range_bad = ~w_fit13 | in_imm[0];
            C_OP_JAL:              w_range_bad = ~w_fit21 | in_imm[0];
            C_OP_LUI, C_OP_AUIPC:  w_range_bad = |in_imm[11:0];
            default:               w_range_bad = 1'b0;
        endcase
    end

    assign w_err = w_unknown | w_range_bad;
`else
    assign w_err = w_unknown;
`endif

    // ------------------------------------------------------------------
    // Handshake, address counter and FIFO
    // ------------------------------------------------------------------
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_addr;
    logic [15:0] r_word_count;
    logic [31:0] r_mem_instr [2];
    logic [31:0] r_mem_addr  [2];
    logic        r_mem_err   [2];

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_base_aligned;
    logic [31:0] w_push_addr;

    // Both handshake outputs depend on registered occupancy only
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);

    assign w_push = in_valid  & in_ready;
    assign w_pop  = out_valid & out_ready;

    assign w_base_aligned = base_addr & 32'hFFFF_FFFC;
    // A coincident reload applies to the word being accepted
    assign w_push_addr    = load_base ? w_base_aligned : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count        <= 2'd0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_addr         <= 32'd0;
            r_word_count   <= 16'd0;
            r_mem_instr[0] <= 32'd0;
            r_mem_instr[1] <= 32'd0;
            r_mem_addr[0]  <= 32'd0;
            r_mem_addr[1]  <= 32'd0;
            r_mem_err[0]   <= 1'b0;
            r_mem_err[1]   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_word;
                r_mem_addr[r_wr_ptr]  <= w_push_addr;
                r_mem_err[r_wr_ptr]   <= w_err;
                r_wr_ptr              <= ~r_wr_ptr;
                r_addr                <= w_push_addr + 32'd4;
            end else if (load_base) begin
                r_addr <= w_base_aligned;
            end

            if (w_pop) begin
                r_rd_ptr     <= ~r_rd_ptr;
                r_word_count <= r_word_count + 16'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero when empty so stale entries never show
    assign out_instr  = out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign out_addr   = out_valid ? r_mem_addr[r_rd_ptr]  : 32'd0;
    assign out_err    = out_valid ? r_mem_err[r_rd_ptr]   : 1'b0;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encode_stream
//  Purpose  : Self-checking bench for instr_encode_stream. Randomized and
//             directed stimulus compared against a format-level reference
//             model with a queue scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encode_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_base = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_func3 = '0;
    logic [6:0]  in_func7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] word_count;

    instr_encode_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_base  (load_base),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_func3   (in_func3),
        .in_func7   (in_func7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] model_addr = '0;
    logic [15:0] model_wc   = '0;
    int          vectors    = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder: fields placed by shift-and-mask from the format tables
    function automatic void ref_encode(
        input  logic [6:0]  op, input logic [4:0] rd, input logic [4:0] rs1,
        input  logic [4:0]  rs2, input logic [2:0] f3, input logic [6:0] f7,
        input  logic [31:0] imm, output logic [31:0] w, output logic e);
        int          si;
        logic [31:0] u;
        logic [31:0] regs;
        bit          bad;
        si   = int'($signed(imm));
        u    = imm;
        regs = (32'(rs1) << 15) | (32'(f3) << 12);
        bad  = 1'b0;
        e    = 1'b0;
        case (op)
            7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w   = (32'(f7) << 25) | ((u & 32'h1F) << 20) | regs | (32'(rd) << 7) | 32'(op);
                    bad = (u > 32'd31);
                end else begin
                    w   = ((u & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'(op);
                    bad = (si < -2048) || (si > 2047);
                end
            end
            7'h23: begin
                w   = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                      | ((u & 32'h1F) << 7) | 32'(op);
                bad = (si < -2048) || (si > 2047);
            end
            7'h63: begin
                w   = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                      | regs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'(op);
                bad = (si < -4096) || (si > 4095) || (u[0] == 1'b1);
            end
            7'h6F: begin
                w   = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7) | 32'(op);
                bad = (si < -1048576) || (si > 1048575) || (u[0] == 1'b1);
            end
            7'h37, 7'h17: begin
                w   = (u & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
                bad = ((u & 32'hFFF) != 0);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
`ifdef ENC_RANGE_CHECK_EN
        if (bad) e = 1'b1;
`else
        if (bad) e = e;
`endif
    endfunction

    // One clock: inputs are already driven; check outputs, then update model.
    task automatic step();
        bit   acc;
        bit   pop;
        ent_t e;
        acc = in_valid && (sb.size() < 2);
        pop = out_ready && (sb.size() != 0);
        check("in_ready",   32'(in_ready),   32'(sb.size() < 2));
        check("out_valid",  32'(out_valid),  32'(sb.size() != 0));
        check("word_count", 32'(word_count), 32'(model_wc));
        if (sb.size() != 0) begin
            check("out_instr", out_instr,      sb[0].instr);
            check("out_addr",  out_addr,       sb[0].addr);
            check("out_err",   32'(out_err),   32'(sb[0].err));
        end
        e = '0;
        if (acc) begin
            ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm,
                       e.instr, e.err);
            e.addr = load_base ? (base_addr & ~32'h3) : model_addr;
        end
        @(posedge clk);
        if (pop) begin
            void'(sb.pop_front());
            model_wc++;
        end
        if (acc) begin
            sb.push_back(e);
            model_addr = e.addr + 32'd4;
        end else if (load_base) begin
            model_addr = base_addr & ~32'h3;
        end
        @(negedge clk);
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_func3 = f3; in_func7 = f7; in_imm = imm;
    endtask

    // Push one word into an empty FIFO, check the head against a fixed value, drain it.
    task automatic directed(input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_instr, input logic exp_err);
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_err"},   32'(out_err), 32'(exp_err));
        out_ready = 1'b1;
        step();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_instr", out_instr,      32'd0);
        check("rst_out_addr",  out_addr,       32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        check("rst_word_cnt",  32'(word_count), 32'd0);
        sb.delete();
        model_addr = '0;
        model_wc   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
    bit         rc_en;

    initial begin
`ifdef ENC_RANGE_CHECK_EN
        rc_en = 1'b1;
`else
        rc_en = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // Test-plan vectors
        directed("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h0050_0093, 1'b0);
        directed("beq",  7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,          32'h0020_8463, 1'b0);
        directed("jal",  7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,        32'h0010_00EF, 1'b0);
        directed("lui",  7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        directed("srai", 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3,         32'h4031_5093, 1'b0);
        directed("unk",  7'h7F, 5'd3, 5'd4, 5'd5, 3'd2, 7'd1, 32'h1234,       32'h0000_0013, 1'b1);
        directed("addi_rng", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,    32'h8000_0013, rc_en);
        directed("beq_odd",  7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,      32'h0020_8163, rc_en);

        // Backpressure with an address reload
        do_reset();
        set_fields(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        out_ready = 1'b0;
        load_base = 1'b1; base_addr = 32'h0000_0103;
        step();
        load_base = 1'b0;
        in_valid  = 1'b1;
        step(); step(); step();
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        check("bp_addr0", out_addr, 32'h100);
        step();
        check("bp_addr1", out_addr, 32'h104);
        step();
        in_valid = 1'b0;
        check("bp_addr2", out_addr, 32'h108);
        step();
        check("bp_word_count", 32'(word_count), 32'd3);
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int mode;
            logic [31:0] imm;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: imm = $urandom;
                1: begin imm = $urandom_range(0, 4095); if (imm[11]) imm |= 32'hFFFF_F000; end
                2: imm = $urandom_range(0, 40);
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            set_fields(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
                       5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            load_base = ($urandom_range(0, 15) == 0);
            base_addr = $urandom;
            step();
        end
        load_base = 1'b0;

        // Reset in the middle of traffic with two words queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(7'h13, 5'd7, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        while (sb.size() < 2) step();
        in_valid = 1'b0;
        do_reset();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_addr",  out_addr, 32'd0);
        check("post_rst_count", 32'(word_count), 32'd0);
        out_ready = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encode_stream.md
# instr_encode_stream

Streaming RV32I instruction encoder: the write-side counterpart of the decode unit. Accepts decoded instruction fields (opcode, rd, rs1, rs2, func3, func7, immediate) over a valid/ready handshake, packs them into the 32-bit instruction word, and tags each word with a sequential byte address. It buffers words in a 2-entry FIFO and emits them over a second valid/ready stream, typically into an instruction-memory loader or test-program generator.

## Interface
- Parameters: none.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_base` in 1: load `base_addr` into the address counter.
- `base_addr` in 32: new address; bits [1:0] are ignored and treated as 0.
- `in_valid` in 1: field set valid.
- `in_ready` out 1: encoder can accept; high when the FIFO holds fewer than 2 entries.
- `in_opcode` in 7, `in_rd` in 5, `in_rs1` in 5, `in_rs2` in 5, `in_func3` in 3, `in_func7` in 7: instruction fields.
- `in_imm` in 32: immediate in decoded form, matching the decode unit's `imm_out`. Sign-extended where applicable; U-type is already shifted left by 12.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_instr` out 32: encoded word.
- `out_addr` out 32: byte address of the word.
- `out_err` out 1: encoding error flag for the head word.
- `word_count` out 16: words popped since reset. Wraps at 0xFFFF.

## Operation
- **Accept:** a field set is accepted when `in_valid & in_ready` at a rising edge. The encoded word, the address counter value and the error flag are written to the FIFO tail. The counter then advances by 4, wrapping modulo 2^32.
- **Encoding by `in_opcode`:**
  - R-type 0110011: {func7, rs2, rs1, func3, rd, op}.
  - I-type 0010011, load 0000011, JALR 1100111: {imm[11:0], rs1, func3, rd, op}.
    - Exception for I-type with func3 = 001 or 101 (shifts): bits [31:25] come from `in_func7` and bits [24:20] from imm[4:0].
  - S-type 0100011: {imm[11:5], rs2, rs1, func3, imm[4:0], op}.
  - B-type 1100011: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - J-type 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - LUI 0110111, AUIPC 0010111: {imm[31:12], rd, op}.
  - Any other opcode: word = 0x00000013 (NOP) and `out_err` = 1. This applies in every build.
- **Pop:** a word leaves the FIFO when `out_valid & out_ready`; `word_count` increments.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - A push is never possible while the FIFO is full, because `in_ready` is low.
- **`load_base`:**
  - Takes effect on the counter at the edge. Words already in the FIFO keep their addresses.
  - If it coincides with an accept, the accepted word gets `base_addr` and the counter becomes `base_addr` + 4.
- **Reset** (asserted any time, including mid-stream): FIFO emptied, counter = 0, `word_count` = 0.
  - Outputs during and after reset: `out_valid` = 0, `in_ready` = 1, `out_instr` = 0, `out_addr` = 0, `out_err` = 0.
  - In-flight words are discarded.

## Timing
- Latency: a word accepted at edge N is visible at `out_valid`/`out_instr` after edge N, when the FIFO was empty. Pass-through is one cycle.
- Throughput: one word per cycle when `out_ready` is held high.
- `in_ready` and `out_valid` are functions of registered FIFO occupancy only. No combinational path from `out_ready` to `in_ready`, nor from `in_valid` to `out_valid`.
- Outputs stay stable while `out_valid & !out_ready`.
- Inputs are sampled only on accept. Changes while `in_ready` = 0 are ignored.

## Configuration
- `ENC_RANGE_CHECK_EN`
  - **Defined:** `out_err` is also set, and the word is still encoded from the truncated bits, when the immediate is not representable in its format:
    - I, S: `in_imm` is not the sign extension of bit 11.
    - Shift I-type: imm[31:5] ≠ 0.
    - B: not a 13-bit signed value, or bit 0 set.
    - J: not a 21-bit signed value, or bit 0 set.
    - LUI, AUIPC: imm[11:0] ≠ 0.
  - **Undefined:** no range checks. `out_err` is set only for unknown opcodes.

## Test plan
- ADDI: opcode 0010011, rd 1, rs1 0, func3 0, imm 5 → `out_instr` 0x00500093, `out_addr` 0x0, `out_err` 0.
- BEQ: opcode 1100011, rs1 1, rs2 2, func3 0, imm 8 → 0x00208463. JAL rd 1, imm 0x800 → 0x001000EF. LUI rd 5, imm 0x12345000 → 0x123452B7.
- Backpressure: `load_base` with `base_addr` 0x100, then 3 back-to-back pushes with `out_ready` = 0 → `in_ready` low after 2 accepts. Release `out_ready` → addresses 0x100, 0x104, then 0x108; `word_count` = 3.
- Unknown opcode 1111111 → `out_instr` 0x00000013, `out_err` 1 in both builds.
- ADDI imm 0x800, rd 0 → `out_instr` 0x80000013 with `out_err` 1 when `ENC_RANGE_CHECK_EN` is defined, 0 when not. BEQ imm 3 → `out_err` 1 only with the macro defined.
- Assert `rst_n` low with 2 words queued → `out_valid` 0 and `in_ready` 1 immediately, no clock edge needed. After release, the next accepted word has `out_addr` 0x0 and `word_count` is 0.
